// File: rtl/doodle_motion.sv
// Doodle kinematics: position, jump rise and vertical speed, updated once per frame_tick.
// Define DOODLE_WRAP_EN for horizontal screen wrap; otherwise x is clamped to [X_MIN, X_MAX].
module doodle_motion #(
  parameter int unsigned START_X      = 459,
  parameter int unsigned START_Y      = 470,
  parameter int unsigned X_MIN        = 157,
  parameter int unsigned X_MAX        = 761,
  parameter int unsigned Y_TOP        = 48,
  parameter int unsigned H_STEP       = 3,
  parameter int unsigned MAX_SPEED    = 8,
  parameter int unsigned ACCEL_FRAMES = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        frame_tick_i,
  input  logic        q_i_i,
  input  logic        q_up_i,
  input  logic        q_down_i,
  input  logic        q_done_i,
  input  logic        is_in_middle_i,
  input  logic        btn_left_i,
  input  logic        btn_right_i,
  output logic [15:0] object_x_o,
  output logic [15:0] object_y_o,
  output logic [9:0]  up_count_o,
  output logic [3:0]  vert_speed_o
);

  localparam int unsigned AccW = $clog2(ACCEL_FRAMES + 1);
  localparam logic [AccW-1:0] AccLast = AccW'(ACCEL_FRAMES - 1);
  localparam logic [16:0] XMin = 17'(X_MIN);
  localparam logic [16:0] XMax = 17'(X_MAX);
  localparam logic [16:0] YTop = 17'(Y_TOP);
  localparam logic [16:0] HStep = 17'(H_STEP);
  localparam logic [16:0] YLimit = 17'd1023;
  localparam logic [3:0] MaxSpeed = 4'(MAX_SPEED);

  typedef enum logic [1:0] {ModeI, ModeUp, ModeDown, ModeDone} mode_e;

  logic [15:0]     x_q, x_d, y_q, y_d;
  logic [9:0]      up_q, up_d;
  logic [3:0]      speed_q, speed_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic            up_prev_q, down_prev_q;

  mode_e       mode;
  logic        up_entry, down_entry, acc_wrap;
  logic [16:0] x_left, x_right, x_next, y_rise, y_fall;
  logic [10:0] up_sum;

  always_comb begin
    unique case ({q_done_i, q_down_i, q_up_i, q_i_i})
      4'b0010: mode = ModeUp;
      4'b0100: mode = ModeDown;
      4'b1000: mode = ModeDone;
      default: mode = ModeI;
    endcase
  end

  assign up_entry   = q_up_i & ~up_prev_q;
  assign down_entry = q_down_i & ~down_prev_q;
  assign acc_wrap   = (acc_q == AccLast);

  // 17-bit arithmetic so a step below zero shows up as a huge value rather than wrapping.
  always_comb begin
    x_left  = {1'b0, x_q} - HStep;
    x_right = {1'b0, x_q} + HStep;
    x_next  = {1'b0, x_q};
    if (btn_left_i && !btn_right_i) begin
      if (x_left[16] || (x_left < XMin)) begin
`ifdef DOODLE_WRAP_EN
        x_next = XMax;
`else
        x_next = XMin;
`endif
      end else begin
        x_next = x_left;
      end
    end else if (btn_right_i && !btn_left_i) begin
      if (x_right > XMax) begin
`ifdef DOODLE_WRAP_EN
        x_next = XMin;
`else
        x_next = XMax;
`endif
      end else begin
        x_next = x_right;
      end
    end
  end

  always_comb begin
    up_sum = {1'b0, up_q} + {7'd0, speed_q};
    y_rise = ({1'b0, y_q} < (YTop + {13'd0, speed_q})) ? YTop
                                                       : ({1'b0, y_q} - {13'd0, speed_q});
    y_fall = {1'b0, y_q} + {13'd0, speed_q};
    if (y_fall > YLimit) y_fall = YLimit;
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    up_d    = up_q;
    speed_d = speed_q;
    acc_d   = acc_q;
    unique case (mode)
      ModeUp: begin
        if (frame_tick_i) x_d = x_next[15:0];
        if (up_entry) begin
          up_d    = '0;
          speed_d = MaxSpeed;
          acc_d   = '0;
        end else if (frame_tick_i) begin
          up_d = up_sum[10] ? 10'd1023 : up_sum[9:0];
          if (!is_in_middle_i) y_d = y_rise[15:0];
          acc_d = acc_wrap ? '0 : acc_q + 1'b1;
          if (acc_wrap && (speed_q > 4'd1)) speed_d = speed_q - 4'd1;
        end
      end
      ModeDown: begin
        if (frame_tick_i) x_d = x_next[15:0];
        if (down_entry) begin
          speed_d = 4'd1;
          acc_d   = '0;
        end else if (frame_tick_i) begin
          y_d   = y_fall[15:0];
          acc_d = acc_wrap ? '0 : acc_q + 1'b1;
          if (acc_wrap && (speed_q < MaxSpeed)) speed_d = speed_q + 4'd1;
        end
      end
      ModeDone: ;
      default: begin
        x_d     = 16'(START_X);
        y_d     = 16'(START_Y);
        up_d    = '0;
        speed_d = '0;
        acc_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q         <= 16'(START_X);
      y_q         <= 16'(START_Y);
      up_q        <= '0;
      speed_q     <= '0;
      acc_q       <= '0;
      up_prev_q   <= 1'b0;
      down_prev_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      up_q        <= up_d;
      speed_q     <= speed_d;
      acc_q       <= acc_d;
      up_prev_q   <= q_up_i;
      down_prev_q <= q_down_i;
    end
  end

  assign object_x_o   = x_q;
  assign object_y_o   = y_q;
  assign up_count_o   = up_q;
  assign vert_speed_o = speed_q;

endmodule

// File: tb/tb_doodle_motion.sv
// Directed bench for doodle_motion; expected values computed by hand from the behaviour.
module tb_doodle_motion;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        q_i = 1'b1, q_up = 1'b0, q_down = 1'b0, q_done = 1'b0;
  logic        in_mid = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
  logic [15:0] obj_x, obj_y;
  logic [9:0]  up_cnt;
  logic [3:0]  speed;

  int n_checks = 0;
  int n_fail = 0;

  doodle_motion dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .frame_tick_i   (frame_tick),
    .q_i_i          (q_i),
    .q_up_i         (q_up),
    .q_down_i       (q_down),
    .q_done_i       (q_done),
    .is_in_middle_i (in_mid),
    .btn_left_i     (btn_l),
    .btn_right_i    (btn_r),
    .object_x_o     (obj_x),
    .object_y_o     (obj_y),
    .up_count_o     (up_cnt),
    .vert_speed_o   (speed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int x, input int y, input int u, input int s);
    check({tag, ".x"}, 32'(obj_x), 32'(x));
    check({tag, ".y"}, 32'(obj_y), 32'(y));
    check({tag, ".up"}, 32'(up_cnt), 32'(u));
    check({tag, ".spd"}, 32'(speed), 32'(s));
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic set_mode(input logic i, input logic u, input logic d, input logic dn);
    q_i = i; q_up = u; q_down = d; q_done = dn;
  endtask

  int up_exp[4] = '{8, 16, 24, 32};
  int y_up_exp[4] = '{462, 454, 446, 438};
  int y_dn_exp[12] = '{432, 433, 434, 435, 437, 439, 441, 443, 446, 449, 452, 455};

  initial begin
    @(negedge clk);
    check_all("reset", 459, 470, 0, 0);
    rst_n = 1'b1;
    idle(2);
    check_all("idle_i", 459, 470, 0, 0);

    // UP entry coincident with tick: loads only
    set_mode(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check_all("up_entry_tick", 459, 470, 0, 8);

    for (int i = 0; i < 4; i++) begin
      tick();
      check("up_rise.up", 32'(up_cnt), 32'(up_exp[i]));
      check("up_rise.y", 32'(obj_y), 32'(y_up_exp[i]));
    end
    check("up_decel.spd", 32'(speed), 32'd7);
    tick();
    check_all("up_tick5", 459, 431, 39, 7);

    in_mid = 1'b1;
    tick();
    check_all("mid1", 459, 431, 46, 7);
    tick();
    tick();
    check_all("mid3", 459, 431, 60, 6);
    in_mid = 1'b0;

    idle(3);
    check_all("hold_no_tick", 459, 431, 60, 6);

    set_mode(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_all("down_entry", 459, 431, 60, 1);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("down_fall.y", 32'(obj_y), 32'(y_dn_exp[i]));
    end
    check_all("down_after12", 459, 455, 60, 4);

    // DONE freezes everything, buttons ignored
    set_mode(1'b0, 1'b0, 1'b0, 1'b1);
    btn_l = 1'b1;
    tick();
    tick();
    check_all("done_frozen", 459, 455, 60, 4);
    btn_l = 1'b0;

    // Async reset mid-DOWN, checked before the next clock edge
    set_mode(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1 check_all("async_reset", 459, 470, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Multiple flags decode as I
    set_mode(1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check_all("multi_flag_i", 459, 470, 0, 0);

    // Walk left 100 ticks to x=159 while falling; y saturates at 1023
    set_mode(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    set_mode(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    btn_l = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    check("walk_left.x", 32'(obj_x), 32'd159);
    check("y_sat", 32'(obj_y), 32'd1023);
    check("spd_cap", 32'(speed), 32'd8);

    tick();
`ifdef DOODLE_WRAP_EN
    check("left_edge.x", 32'(obj_x), 32'd761);
`else
    check("left_edge.x", 32'(obj_x), 32'd157);
`endif
    btn_r = 1'b1;
    tick();
`ifdef DOODLE_WRAP_EN
    check("both_btn.x", 32'(obj_x), 32'd761);
`else
    check("both_btn.x", 32'(obj_x), 32'd157);
`endif
    btn_l = 1'b0;
    tick();
`ifdef DOODLE_WRAP_EN
    check("right_edge.x", 32'(obj_x), 32'd157);
`else
    check("right_step.x", 32'(obj_x), 32'd160);
`endif
    btn_r = 1'b0;
    btn_l = 1'b1;
    tick();
`ifdef DOODLE_WRAP_EN
    check("left_wrap2.x", 32'(obj_x), 32'd761);
`else
    check("left_clamp2.x", 32'(obj_x), 32'd157);
`endif
    btn_l = 1'b0;
    check("y_hold_sat", 32'(obj_y), 32'd1023);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
